// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0]  ALIGN_MASK         = 2'b11;
  localparam logic [31:0] READ_ERR_DATA      = 32'h0;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Variable-latency req/ack data-memory port; master issues requests, slave answers with a one-cycle ack.
interface mem_access_ctrl_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_timeout_ctr.sv
// Clearable ACCESS-cycle counter; expired_o asserts combinationally in the LIMIT-th enabled cycle.
// Compiled only when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic startin,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q >= W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: stalls the pipeline while a req/ack access is in flight (IDLE/ACCESS/DONE).
// Occupancy is ack latency + 2 cycles; optional ACCESS timeout under MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     startin,
  input  logic                     MEM_mem_read,
  input  logic                     MEM_mem_write,
  input  logic [31:0]              MEM_alu_result,
  input  logic [31:0]              MEM_forward_b_mux_out,
  mem_access_ctrl_if.master        dmem,
  output logic [31:0]              MEM_read_data,
  output logic                     stall,
  output logic                     mem_error,
  output logic [31:0]              stall_count
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  logic any_req;
  logic access_vld;
  logic misaligned;
  logic timeout_hit;

  assign any_req    = MEM_mem_read | MEM_mem_write;
  assign access_vld = any_req && is_aligned(MEM_alu_result);
  assign misaligned = any_req && !is_aligned(MEM_alu_result);

  // Detection stalls in the same cycle so EX/MEM cannot move before the request is latched.
  assign stall = startin && ((state_q == IDLE && access_vld) || state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic to_expired;

  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timeout (
    .clk       (clk),
    .startin   (startin),
    .clr_i     (state_q == IDLE && access_vld),
    .en_i      (state_q == ACCESS),
    .expired_o (to_expired)
  );

  assign timeout_hit = (state_q == ACCESS) && to_expired && !dmem.ack;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_vld) begin
            addr_q  <= MEM_alu_result;
            wdata_q <= MEM_forward_b_mux_out;
            we_q    <= MEM_mem_write;
            req_q   <= 1'b1;
            state_q <= ACCESS;
            if (MEM_mem_read && MEM_mem_write) err_q <= 1'b1;
          end else if (misaligned) begin
            rdata_q <= READ_ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        ACCESS: begin
          if (dmem.ack) begin
            if (!we_q) rdata_q <= dmem.rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (timeout_hit) begin
            rdata_q <= READ_ERR_DATA;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign dmem.req      = req_q;
  assign dmem.we       = we_q;
  assign dmem.addr     = addr_q;
  assign dmem.wdata    = wdata_q;
  assign MEM_read_data = rdata_q;
  assign mem_error     = err_q;
  assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reads, store/load back-to-back, misalignment, reset mid-access, R+W, timeout.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk;
  logic        startin;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_forward_b_mux_out;
  logic [31:0] MEM_read_data;
  logic        stall;
  logic        mem_error;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl_if dmem ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                   (clk),
    .startin               (startin),
    .MEM_mem_read          (MEM_mem_read),
    .MEM_mem_write         (MEM_mem_write),
    .MEM_alu_result        (MEM_alu_result),
    .MEM_forward_b_mux_out (MEM_forward_b_mux_out),
    .dmem                  (dmem),
    .MEM_read_data         (MEM_read_data),
    .stall                 (stall),
    .mem_error             (mem_error),
    .stall_count           (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    MEM_mem_read          = rd;
    MEM_mem_write         = wr;
    MEM_alu_result        = a;
    MEM_forward_b_mux_out = wd;
  endtask

  initial begin
    startin    = 1'b0;
    dmem.ack   = 1'b0;
    dmem.rdata = 32'h0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("rst_req",       32'(dmem.req),   32'h0);
    chk("rst_we",        32'(dmem.we),    32'h0);
    chk("rst_addr",      dmem.addr,       32'h0);
    chk("rst_wdata",     dmem.wdata,      32'h0);
    chk("rst_rdata",     MEM_read_data,   32'h0);
    chk("rst_stall",     32'(stall),      32'h0);
    chk("rst_err",       32'(mem_error),  32'h0);
    chk("rst_stall_cnt", stall_count,     32'h0);

    @(negedge clk);
    startin = 1'b1;
    step();

    // Read 0x100, ack in the second ACCESS cycle
    set_in(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    chk("rd_detect_stall", 32'(stall),    32'h1);
    chk("rd_detect_noreq", 32'(dmem.req), 32'h0);
    step();
    chk("rd_a1_req",   32'(dmem.req), 32'h1);
    chk("rd_a1_we",    32'(dmem.we),  32'h0);
    chk("rd_a1_addr",  dmem.addr,     32'h100);
    chk("rd_a1_stall", 32'(stall),    32'h1);
    step();
    chk("rd_a2_stall", 32'(stall),    32'h1);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hCAFE0001;
    step();
    dmem.ack   = 1'b0;
    chk("rd_done_req",   32'(dmem.req),  32'h0);
    chk("rd_done_stall", 32'(stall),     32'h0);
    chk("rd_done_data",  MEM_read_data,  32'hCAFE0001);
    chk("rd_stall_cnt",  stall_count,    32'd3);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rd_idle_stall", 32'(stall),  32'h0);
    chk("rd_idle_cnt",   stall_count, 32'd3);

    // Store 0x40 then immediate load 0x44
    set_in(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5);
    step();
    chk("st_req",   32'(dmem.req), 32'h1);
    chk("st_we",    32'(dmem.we),  32'h1);
    chk("st_addr",  dmem.addr,     32'h40);
    chk("st_wdata", dmem.wdata,    32'hA5A5A5A5);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hBAD0BAD0;
    step();
    dmem.ack   = 1'b0;
    chk("st_done_req",   32'(dmem.req), 32'h0);
    chk("st_done_stall", 32'(stall),    32'h0);
    chk("st_hold_data",  MEM_read_data, 32'hCAFE0001);
    set_in(1'b1, 1'b0, 32'h44, 32'h0);
    step();
    chk("ld_detect_stall", 32'(stall), 32'h1);
    step();
    chk("ld_req",  32'(dmem.req), 32'h1);
    chk("ld_we",   32'(dmem.we),  32'h0);
    chk("ld_addr", dmem.addr,     32'h44);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h12345678;
    step();
    dmem.ack   = 1'b0;
    chk("ld_data",      MEM_read_data, 32'h12345678);
    chk("ld_stall_cnt", stall_count,   32'd7);
    chk("ld_no_err",    32'(mem_error), 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Misaligned read at 0x102
    set_in(1'b1, 1'b0, 32'h102, 32'h0);
    #1;
    chk("mis_stall", 32'(stall), 32'h0);
    step();
    chk("mis_req",  32'(dmem.req),   32'h0);
    chk("mis_err",  32'(mem_error),  32'h1);
    chk("mis_data", MEM_read_data,   32'h0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("mis_req2", 32'(dmem.req), 32'h0);
    chk("mis_cnt",  stall_count,   32'd7);

    // Reset during ACCESS, then a late ack
    set_in(1'b1, 1'b0, 32'h200, 32'h0);
    step();
    chk("rst_mid_req", 32'(dmem.req), 32'h1);
    #2;
    startin = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_mid_req_drop", 32'(dmem.req),  32'h0);
    chk("rst_mid_stall",    32'(stall),     32'h0);
    chk("rst_mid_cnt",      stall_count,    32'h0);
    chk("rst_mid_err",      32'(mem_error), 32'h0);
    @(negedge clk);
    startin    = 1'b1;
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hDEADBEEF;
    step();
    dmem.ack   = 1'b0;
    chk("late_ack_req",   32'(dmem.req), 32'h0);
    chk("late_ack_stall", 32'(stall),    32'h0);
    chk("late_ack_data",  MEM_read_data, 32'h0);
    chk("late_ack_cnt",   stall_count,   32'h0);

    // Read and write together: write to 0x8 with error flag
    set_in(1'b1, 1'b1, 32'h8, 32'h00000011);
    step();
    chk("rw_req",   32'(dmem.req),  32'h1);
    chk("rw_we",    32'(dmem.we),   32'h1);
    chk("rw_addr",  dmem.addr,      32'h8);
    chk("rw_wdata", dmem.wdata,     32'h00000011);
    chk("rw_err",   32'(mem_error), 32'h1);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h77777777;
    step();
    dmem.ack   = 1'b0;
    chk("rw_data_held", MEM_read_data, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();

`ifdef MEM_TIMEOUT_EN
    // Timeout: load a known value, clear error via reset, then never ack
    @(negedge clk);
    startin = 1'b0;
    @(negedge clk);
    startin = 1'b1;
    step();
    set_in(1'b1, 1'b0, 32'h300, 32'h0);
    step();
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h55AA55AA;
    step();
    dmem.ack   = 1'b0;
    chk("to_pre_data", MEM_read_data, 32'h55AA55AA);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    set_in(1'b1, 1'b0, 32'h304, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("to_a%0d_req", i), 32'(dmem.req), 32'h1);
    end
    step();
    chk("to_req_drop", 32'(dmem.req),  32'h0);
    chk("to_stall",    32'(stall),     32'h0);
    chk("to_err",      32'(mem_error), 32'h1);
    chk("to_data",     MEM_read_data,  32'h0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("to_resume_stall", 32'(stall), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
